// File: rtl/keypad_scan_fifo.sv
// keypad_scan_fifo
//   Matrix keypad scanner with whole-frame debounce, multi-key detection,
//   optional typematic repeat and an event FIFO of key codes.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-low
//   row        keypad rows, active-low (0 = key down in the driven column)
//   col        column drive, active-low one-hot
//   mode       0 = one event per press, 1 = typematic repeat
//   key_rd     pop FIFO head (ignored while key_valid=0)
//   ovf_clr    clear the sticky overflow flag
//   key_code   FIFO head code = col_index*ROWS + row_index (0 when empty)
//   key_valid  FIFO non-empty
//   multi      accepted frame has more than one key down
//   overflow   sticky: an event was dropped because the FIFO was full
module keypad_scan_fifo #(
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int DIV         = 50000,
    parameter int DEBOUNCE    = 3,
    parameter int REPEAT_DLY  = 32,
    parameter int REPEAT_RATE = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int CW          = $clog2(ROWS*COLS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ROWS-1:0] row,
    output logic [COLS-1:0] col,
    input  logic            mode,
    input  logic            key_rd,
    input  logic            ovf_clr,
    output logic [CW-1:0]   key_code,
    output logic            key_valid,
    output logic            multi,
    output logic            overflow
);

    localparam int N   = ROWS * COLS;
    localparam int DW  = $clog2(DIV);
    localparam int CIW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SW  = $clog2(DEBOUNCE + 1);
    localparam int RW  = $clog2(REPEAT_DLY + REPEAT_RATE + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int NW  = $clog2(FIFO_DEPTH + 1);

    function automatic int unsigned popcnt(input logic [N-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

    // Code of the (single) set bit; only meaningful when popcnt(v)==1.
    function automatic logic [CW-1:0] code_of(input logic [N-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) c = CW'(i);
        end
        return c;
    endfunction

    logic [DW-1:0]  div_q,  div_d;
    logic [CIW-1:0] c_q,    c_d;
    logic [N-1:0]   snap_q, snap_d;
    logic [N-1:0]   prev_q, prev_d;
    logic [N-1:0]   acc_q,  acc_d;
    logic [SW-1:0]  stab_q, stab_d;
    logic [RW-1:0]  rep_q,  rep_d;
    logic           multi_q, multi_d;
    logic           ovf_q,  ovf_d;
    logic [AW-1:0]  wp_q,   rp_q;
    logic [NW-1:0]  cnt_q,  cnt_d;
    logic [CW-1:0]  mem_q [FIFO_DEPTH];

    logic           tick, frame_end, a_chg, push, pop, wr;
    logic [N-1:0]   frame;

    assign tick      = (div_q == DW'(DIV - 1));
    assign frame_end = tick && (c_q == CIW'(COLS - 1));
    assign col       = ~(COLS'(1) << c_q);

    always_comb begin
        div_d   = tick ? '0 : div_q + 1'b1;
        c_d     = c_q;
        if (tick) c_d = (c_q == CIW'(COLS - 1)) ? '0 : c_q + 1'b1;

        snap_d  = snap_q;
        prev_d  = prev_q;
        acc_d   = acc_q;
        stab_d  = stab_q;
        rep_d   = rep_q;
        multi_d = multi_q;
        a_chg   = 1'b0;
        push    = 1'b0;

        // Snapshot with the column being sampled right now merged in, so the
        // frame-end tick compares the fully completed frame.
        frame = snap_q;
        for (int r = 0; r < ROWS; r++) begin
            frame[int'(c_q) * ROWS + r] = ~row[r];
        end
        if (tick) snap_d = frame;

        if (frame_end) begin
            if (frame != prev_q) begin
                prev_d = frame;
                stab_d = '0;
            end else if (stab_q != SW'(DEBOUNCE)) begin
                stab_d = stab_q + 1'b1;
                if (stab_d == SW'(DEBOUNCE)) begin
                    acc_d   = frame;
                    multi_d = (popcnt(frame) > 1);
                    if (frame != acc_q) begin
                        a_chg = 1'b1;
                        if (popcnt(frame) == 1) push = 1'b1;
                    end
                end
            end

            // Repeat counter folds back to REPEAT_DLY after each rate period
            // so it never needs more than DLY+RATE states.
            if (a_chg || !mode || popcnt(acc_q) != 1) begin
                rep_d = '0;
            end else begin
                rep_d = rep_q + 1'b1;
                if (rep_d == RW'(REPEAT_DLY)) begin
                    push = 1'b1;
                end else if (rep_d == RW'(REPEAT_DLY + REPEAT_RATE)) begin
                    push  = 1'b1;
                    rep_d = RW'(REPEAT_DLY);
                end
            end
        end
        if (!mode) rep_d = '0;
    end

    // A full FIFO still accepts a push when a pop frees a slot the same cycle.
    assign pop = key_rd && (cnt_q != '0);
    assign wr  = push && ((cnt_q != NW'(FIFO_DEPTH)) || pop);

    always_comb begin
        cnt_d = cnt_q;
        case ({wr, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        // Set wins over clear.
        ovf_d = ovf_q;
        if (push && !wr)  ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q   <= '0;
            c_q     <= '0;
            snap_q  <= '0;
            prev_q  <= '0;
            acc_q   <= '0;
            stab_q  <= '0;
            rep_q   <= '0;
            multi_q <= 1'b0;
            ovf_q   <= 1'b0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
        end else begin
            div_q   <= div_d;
            c_q     <= c_d;
            snap_q  <= snap_d;
            prev_q  <= prev_d;
            acc_q   <= acc_d;
            stab_q  <= stab_d;
            rep_q   <= rep_d;
            multi_q <= multi_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            if (wr)  wp_q <= wp_q + 1'b1;
            if (pop) rp_q <= rp_q + 1'b1;
        end
    end

    // Storage carries data only; validity comes from cnt_q.
    always_ff @(posedge clk) begin
        if (wr) mem_q[wp_q] <= code_of(acc_d);
    end

    assign key_valid = (cnt_q != '0);
    assign key_code  = key_valid ? mem_q[rp_q] : '0;
    assign multi     = multi_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
module tb_keypad_scan_fifo;

    localparam int DEB   = 2;
    localparam int DLY   = 4;
    localparam int RATE  = 2;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] row;
    logic [3:0] col;
    logic       mode = 1'b0, key_rd = 1'b0, ovf_clr = 1'b0;
    logic [3:0] key_code;
    logic       key_valid, multi, overflow;

    bit [15:0]  keys = '0;
    int         total = 0, bad = 0;

    localparam bit [15:0] K9 = 16'h0200;
    localparam bit [15:0] K2 = 16'h0004;

    // Reference model state (frame level)
    bit [15:0]  mP, mA;
    int         mCnt, mRep;
    bit         mMulti, mOvf;
    int         mq[$];

    keypad_scan_fifo #(
        .ROWS(4), .COLS(4), .DIV(2), .DEBOUNCE(DEB), .REPEAT_DLY(DLY),
        .REPEAT_RATE(RATE), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .row(row), .col(col), .mode(mode),
        .key_rd(key_rd), .ovf_clr(ovf_clr), .key_code(key_code),
        .key_valid(key_valid), .multi(multi), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row = 4'b1111;
        for (int c = 0; c < 4; c++)
            if (!col[c])
                for (int r = 0; r < 4; r++)
                    if (keys[c*4 + r]) row[r] = 1'b0;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic int key_index(input bit [15:0] f);
        int idx;
        idx = 0;
        for (int i = 0; i < 16; i++) if (f[i]) idx = i;
        return idx;
    endfunction

    task automatic model_reset();
        mP = '0; mA = '0; mCnt = 0; mRep = 0; mMulti = 0; mOvf = 0;
        mq.delete();
    endtask

    // One completed frame f; pop_now means a read coincided with the frame end.
    task automatic model_frame(input bit [15:0] f, input bit pop_now);
        bit push, changed;
        push = 0; changed = 0;
        if (f != mP) begin
            mP = f; mCnt = 0;
        end else if (mCnt < DEB) begin
            mCnt++;
            if (mCnt == DEB) begin
                changed = (f != mA);
                mA = f;
                mMulti = ($countones(f) > 1);
                if (changed && $countones(f) == 1) push = 1;
            end
        end
        if (changed || !mode || $countones(mA) != 1) begin
            mRep = 0;
        end else begin
            mRep++;
            if (mRep >= DLY && ((mRep - DLY) % RATE) == 0) push = 1;
        end
        if (pop_now && mq.size() > 0) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < DEPTH) mq.push_back(key_index(mA));
            else mOvf = 1;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0; key_rd = 0; ovf_clr = 0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        rst = 1'b1;
        model_reset();
    endtask

    // Eight cycles = one frame; called aligned so the 8th edge is the frame end.
    task automatic run_frame(input bit [15:0] k, input bit rd_first,
                             input bit rd_last, input bit clr_first);
        keys = k;
        for (int j = 1; j <= 8; j++) begin
            key_rd  = (j == 1 && rd_first) || (j == 8 && rd_last);
            ovf_clr = (j == 1 && clr_first);
            @(posedge clk); #1;
            key_rd = 0; ovf_clr = 0;
            if (j == 1) begin
                if (rd_first && mq.size() > 0) void'(mq.pop_front());
                if (clr_first) mOvf = 0;
            end
        end
        model_frame(k, rd_last);
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        keys = '0; mode = 0;
        apply_reset();
        total++; if (col !== 4'b1110) begin bad++; $display("FAIL reset_col got=%b exp=1110", col); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
        total++; if (key_code !== 4'd0) begin bad++; $display("FAIL reset_code got=%0d exp=0", key_code); end
        total++; if (multi !== 1'b0) begin bad++; $display("FAIL reset_multi got=%b exp=0", multi); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        release_reset();
        for (int k = 0; k < 16; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            exp_col = ~(4'b0001 << ((k / 2) % 4));
            total++;
            if (col !== exp_col) begin bad++; $display("FAIL col_seq k=%0d got=%b exp=%b", k, col, exp_col); end
        end
        @(posedge clk); #1;
        model_frame('0, 0);
        model_frame('0, 0);
    endtask

    task automatic test_single();
        mode = 0;
        for (int f = 1; f <= 10; f++) begin
            run_frame(K9, 0, 0, 0);
            if (f == 2) begin
                total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL single_early got=%b exp=0", key_valid); end
            end
            if (f == 3) begin
                total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL single_rise got=%b exp=1", key_valid); end
                total++; if (key_code !== 4'd9) begin bad++; $display("FAIL single_code got=%0d exp=9", key_code); end
            end
        end
        total++; if (key_code !== 4'd9 || key_valid !== 1'b1) begin bad++; $display("FAIL single_hold got=%0d/%b exp=9/1", key_code, key_valid); end
        run_frame(K9, 1, 0, 0);
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL single_pop got=%b exp=0", key_valid); end
        for (int f = 0; f < 3; f++) run_frame(K9, 0, 0, 0);
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL single_noevt got=%b exp=0", key_valid); end
        for (int f = 0; f < 3; f++) run_frame('0, 0, 0, 0);
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL single_release got=%b exp=0", key_valid); end
    endtask

    task automatic test_alternate();
        mode = 0;
        for (int f = 0; f < 12; f++) begin
            run_frame((f % 2 == 0) ? K9 : 16'h0000, 0, 0, 0);
            total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL alt_valid f=%0d got=%b exp=0", f, key_valid); end
        end
        for (int f = 0; f < 3; f++) run_frame('0, 0, 0, 0);
    endtask

    task automatic test_multi();
        mode = 0;
        for (int f = 0; f < 4; f++) run_frame(K9 | K2, 0, 0, 0);
        total++; if (multi !== 1'b1) begin bad++; $display("FAIL multi_set got=%b exp=1", multi); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL multi_nopush got=%b exp=0", key_valid); end
        for (int f = 0; f < 4; f++) run_frame(K9, 0, 0, 0);
        total++; if (multi !== 1'b0) begin bad++; $display("FAIL multi_clr got=%b exp=0", multi); end
        total++; if (key_valid !== 1'b1 || key_code !== 4'd9) begin bad++; $display("FAIL multi_to_single got=%0d/%b exp=9/1", key_code, key_valid); end
        run_frame(K9, 1, 0, 0);
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL multi_once got=%b exp=0", key_valid); end
        for (int f = 0; f < 3; f++) run_frame('0, 0, 0, 0);
    endtask

    task automatic test_repeat_full();
        mode = 1;
        for (int f = 1; f <= 13; f++) begin
            run_frame(K9, 0, 0, 0);
            if (f == 3) begin
                total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL rep_first got=%b exp=1", key_valid); end
            end
            if (f == 12) begin
                total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rep_ovf_early got=%b exp=0", overflow); end
            end
        end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL rep_ovf got=%b exp=1", overflow); end
        run_frame(K9, 0, 0, 0);
        run_frame(K9, 0, 1, 0);   // repeat push meets a read on a full FIFO
        total++; if (overflow !== 1'b1 || key_valid !== 1'b1) begin bad++; $display("FAIL pushpop_full got=%b/%b exp=1/1", overflow, key_valid); end
        mode = 0;
        for (int p = 0; p < 4; p++) begin
            total++; if (key_valid !== 1'b1 || key_code !== 4'd9) begin bad++; $display("FAIL drain p=%0d got=%0d/%b exp=9/1", p, key_code, key_valid); end
            run_frame(K9, 1, 0, p == 0);
            if (p == 0) begin
                total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
            end
        end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", key_valid); end
        for (int f = 0; f < 3; f++) run_frame('0, 0, 0, 0);
    endtask

    task automatic test_random();
        bit [15:0] k;
        int        n, len;
        bit        rdf, rdl, clr;
        logic [3:0] ec;
        for (int seg = 0; seg < 20; seg++) begin
            mode = 1'($urandom_range(0, 1));
            n = $urandom_range(0, 2);
            k = '0;
            for (int i = 0; i < n; i++) k[$urandom_range(0, 15)] = 1'b1;
            len = $urandom_range(1, 7);
            for (int l = 0; l < len; l++) begin
                rdf = ($urandom_range(0, 2) == 0);
                rdl = ($urandom_range(0, 3) == 0);
                clr = ($urandom_range(0, 5) == 0);
                run_frame(k, rdf, rdl, clr);
                ec = (mq.size() > 0) ? 4'(mq[0]) : 4'd0;
                total++; if (key_valid !== (mq.size() > 0)) begin bad++; $display("FAIL rnd_valid seg=%0d got=%b exp=%b", seg, key_valid, mq.size() > 0); end
                total++; if (key_code !== ec) begin bad++; $display("FAIL rnd_code seg=%0d got=%0d exp=%0d", seg, key_code, ec); end
                total++; if (multi !== mMulti) begin bad++; $display("FAIL rnd_multi seg=%0d got=%b exp=%b", seg, multi, mMulti); end
                total++; if (overflow !== mOvf) begin bad++; $display("FAIL rnd_ovf seg=%0d got=%b exp=%b", seg, overflow, mOvf); end
            end
        end
    endtask

    task automatic test_midreset();
        mode = 0;
        for (int f = 0; f < 3; f++) run_frame(K2, 0, 0, 0);
        for (int f = 0; f < 4; f++) run_frame(K9, 0, 0, 0);
        keys = K2;
        repeat (3) @(posedge clk);
        #1;
        apply_reset();
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", key_valid); end
        total++; if (multi !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL midrst_flags got=%b/%b exp=0/0", multi, overflow); end
        release_reset();
        run_frame(K9, 0, 0, 0);
        run_frame(K9, 0, 0, 0);
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL midrst_debounce got=%b exp=0", key_valid); end
        run_frame(K9, 0, 0, 0);
        total++; if (key_valid !== 1'b1 || key_code !== 4'd9) begin bad++; $display("FAIL midrst_accept got=%0d/%b exp=9/1", key_code, key_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_multi();
        test_repeat_full();
        test_random();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
